// File: rtl/uart_rx_if.sv
// Serial-side bundle of the UART receiver: tick/line inputs and word/flag outputs.
// The master modport is the driver side (baud generator, pin); the slave modport is the receiver.
interface uart_rx_if #(
    parameter int SIZE_TRAMA_BIT = 8
);
    logic                      i_tick;
    logic                      i_rx;
    logic [SIZE_TRAMA_BIT-1:0] o_data;
    logic                      o_flag_rx_done;
    logic                      o_flag_frame_err;

    modport master (
        output i_tick,
        output i_rx,
        input  o_data,
        input  o_flag_rx_done,
        input  o_flag_frame_err
    );

    modport slave (
        input  i_tick,
        input  i_rx,
        output o_data,
        output o_flag_rx_done,
        output o_flag_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver oversampling at 16x baud; LSB-first frames, registered
// done / framing-error pulses, break hold-off after a low stop bit.
module uart_rx #(
    parameter int SIZE_TRAMA_BIT   = 8,
    parameter int SIZE_BIT_COUNTER = 3
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_rx_if.slave bus
);

    // One-cold encoding: exactly one bit low per legal state.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b11110,
        ST_START = 5'b11101,
        ST_DATA  = 5'b11011,
        ST_STOP  = 5'b10111,
        ST_BREAK = 5'b01111
    } state_t;

    localparam logic [SIZE_BIT_COUNTER-1:0] LAST_BIT = SIZE_BIT_COUNTER'(SIZE_TRAMA_BIT - 1);

    state_t                      state_q, state_d;
    logic                        sync1_q, sync2_q;
    logic [3:0]                  tick_cnt_q, tick_cnt_d;
    logic [SIZE_BIT_COUNTER-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE_TRAMA_BIT-1:0]   shift_q, shift_d;
    logic [SIZE_TRAMA_BIT-1:0]   data_q, data_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= bus.i_rx;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end

            ST_START: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        // Right shift: the first (LSB) bit walks down to bit 0 by the end.
                        shift_d    = {rx_s, shift_q[SIZE_TRAMA_BIT-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            ST_STOP: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_data           = data_q;
    assign bus.o_flag_rx_done   = done_q;
    assign bus.o_flag_frame_err = err_q;

endmodule
